cjtag_bridge_v2: RTL and testbench
==================================

// Module: cjtag_bridge_v2
// PURPOSE
//  Parametrised second-generation cJTAG (IEEE 1149.7 OScan1) to 4-wire JTAG bridge.
//  - Oversamples the TCKC/TMSC pair on clk_i and decodes escapes (deselect, select, reset).
//  - Checks the 12-bit activation packet and converts 3-bit OScan1 packets into TCK/TDI/TMS/TDO.
//  - Sits between the debug pad pair and the core TAP.
//  - Beyond the first-generation bridge: configurable escape thresholds and activation codes,
//    a deselect escape, activation error reporting, and an optional auto TAP reset after a reset escape.
// PARAMETERS
//  SYNC_STAGES    2        input synchroniser depth on tckc_i/tmsc_i (>=2)
//  DES_ESC_MIN    4        minimum TMSC toggles (TCKC high) for a deselect escape
//  SEL_ESC_MIN    6        minimum toggles for a selection escape
//  RST_ESC_MIN    8        minimum toggles for a reset escape; the toggle counter saturates at 15
//  OAC            4'b1100  expected online activation code
//  EC             4'b1000  expected extension code
//  CHECK_CP       0        1: require odd parity over {CP,EC,OAC}
//  TAP_RST_PULSES 5        TCK pulses with TMS=1 issued after a reset escape (0 = disabled)
//  TCK_HALF       4        clk_i cycles per half-period of auto-reset TCK pulses
// PORTS
//  clk_i      in   1  system clock; all logic is on the rising edge
//  rst_i      in   1  synchronous, active-high reset
//  tckc_i     in   1  cJTAG clock from pad (asynchronous)
//  tmsc_i     in   1  cJTAG data from pad (asynchronous)
//  tmsc_o     out  1  TMSC drive value (TDO)
//  tmsc_oe_o  out  1  TMSC output enable
//  tck_o      out  1  JTAG TCK to TAP
//  tdi_o      out  1  JTAG TDI
//  tms_o      out  1  JTAG TMS
//  tdo_i      in   1  JTAG TDO from TAP
//  online_o   out  1  1 while in ONLINE state
//  err_o      out  1  one-cycle pulse when an activation packet is rejected
//  state_o    out  3  current FSM state, for debug
// BEHAVIOUR
//  Reset values
//   - tmsc_o=0, tmsc_oe_o=0, tck_o=0, tdi_o=0, tms_o=1, online_o=0, err_o=0.
//   - state=OFFLINE. Synchronisers, toggle counter and phase counter are all cleared.
//  Input conditioning
//   - tckc_i and tmsc_i each pass through SYNC_STAGES flops, then one edge-detect flop.
//   - A pad edge is acted on SYNC_STAGES+1 clk_i cycles later.
//  Escape detection
//   - Counting: each synced TMSC edge while synced TCKC=1 and tmsc_oe_o=0 increments the
//     toggle count (saturating at 15).
//   - Evaluation happens on the TCKC falling edge, after which the count clears.
//   - count >= RST_ESC_MIN: go to OFFLINE in any state; start the auto TAP reset if enabled.
//   - count in [SEL_ESC_MIN, RST_ESC_MIN-1]: OFFLINE -> ACTIVATE; ignored in other states.
//   - count in [DES_ESC_MIN, SEL_ESC_MIN-1]: ONLINE -> OFFLINE; ignored in other states.
//   - count in [1, DES_ESC_MIN-1]: treated as a glitch and ignored; the falling edge is not
//     otherwise processed.
//   - Any escape clears the phase counter, forces tck_o=0 and forces tmsc_oe_o=0.
//  FSM states: OFFLINE(0), ACTIVATE(1), ONLINE(2), TAPRST(3)
//   - ACTIVATE:
//     - Sample TMSC on each TCKC rise into a 12-bit shift register, LSB first:
//       OAC[3:0], then EC[3:0], then CP[3:0].
//     - After the 12th bit, accept if OAC and EC match and (CHECK_CP==0 or ^{CP,EC,OAC}==1).
//       Accept -> ONLINE.
//     - Otherwise pulse err_o -> OFFLINE.
//   - ONLINE (OScan1): a phase counter (0..2) advances on each TCKC rise and wraps 2->0.
//     - Phase 0 rise: tdi_o <= ~tmsc (the wire carries nTDI).
//     - Phase 1 rise: tms_o <= tmsc.
//     - TCKC fall ending phase 1: tmsc_o <= tdo_i; tmsc_oe_o <= 1.
//     - Phase 2 rise: tck_o <= 1.
//     - TCKC fall ending phase 2: tck_o <= 0; tmsc_oe_o <= 0.
//     - Net effect: one TCK pulse per 3-bit packet, with TDI/TMS stable for at least one
//       TCKC half-period before the TCK rise.
//   - TAPRST:
//     - Hold tms_o=1 and emit TAP_RST_PULSES TCK pulses, each TCK_HALF cycles high and
//       TCK_HALF cycles low, then -> OFFLINE.
//     - TCKC/TMSC activity during TAPRST is counted but only evaluated once back in OFFLINE.
//  OFFLINE: tck_o=0, tms_o=1, tmsc_oe_o=0.
//  Boundary cases
//   - rst_i mid-packet: everything returns to reset values on the next clk_i edge.
//   - Escape mid-packet: the partial packet is discarded and no TCK pulse is issued.
//   - Simultaneous TCKC and TMSC edges in one clk_i cycle: the TCKC edge is processed and the
//     TMSC edge is not counted.
// TESTING
//  1. TCKC=1, 10 TMSC toggles, TCKC fall -> state TAPRST.
//     - Check: 5 tck_o pulses with tms_o=1, then OFFLINE and online_o=0.
//  2. 7-toggle escape, then OAC 0,0,1,1 / EC 0,0,0,1 / CP 0,0,0,0 (LSB first) -> ONLINE and
//     online_o=1 after the 12th rise.
//  3. ONLINE, packet nTDI=0, TMS=1, tdo_i=1.
//     - Check: tdi_o=1 and tms_o=1 before the tck_o rise.
//     - Check: tmsc_oe_o=1 and tmsc_o=1 during phase 2.
//     - Check: exactly one tck_o pulse.
//  4. Activation with OAC=0,1,1,1 -> err_o pulses for 1 cycle; state OFFLINE; no tck_o activity.
//  5. ONLINE, 5-toggle escape -> OFFLINE.
//     - Check: a following 2-toggle glitch is ignored; a 6-toggle escape re-enters ACTIVATE.
//  6. rst_i asserted during phase 2 with tck_o=1 and tmsc_oe_o=1.
//     - Check: the next cycle has tck_o=0, tmsc_oe_o=0, tms_o=1 and state OFFLINE.

Source files
------------

// File: rtl/cjtag_bridge_v2.sv
// cJTAG OScan1 to 4-wire JTAG bridge: synchronises the TCKC/TMSC pad pair, decodes
// escapes, checks the activation packet and converts 3-bit packets into TCK/TDI/TMS/TDO.
module cjtag_bridge_v2 #(
   parameter int         SYNC_STAGES    = 2,
   parameter int         DES_ESC_MIN    = 4,
   parameter int         SEL_ESC_MIN    = 6,
   parameter int         RST_ESC_MIN    = 8,
   parameter logic [3:0] OAC            = 4'b1100,
   parameter logic [3:0] EC             = 4'b1000,
   parameter int         CHECK_CP       = 0,
   parameter int         TAP_RST_PULSES = 5,
   parameter int         TCK_HALF       = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tckc_i,
   input  logic       tmsc_i,
   output logic       tmsc_o,
   output logic       tmsc_oe_o,
   output logic       tck_o,
   output logic       tdi_o,
   output logic       tms_o,
   input  logic       tdo_i,
   output logic       online_o,
   output logic       err_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      ST_OFFLINE  = 3'd0,
      ST_ACTIVATE = 3'd1,
      ST_ONLINE   = 3'd2,
      ST_TAPRST   = 3'd3
   } state_t;

   localparam logic [3:0]  DES_L   = 4'(DES_ESC_MIN);
   localparam logic [3:0]  SEL_L   = 4'(SEL_ESC_MIN);
   localparam logic [3:0]  RST_L   = 4'(RST_ESC_MIN);
   localparam logic [15:0] HALF_L  = 16'(TCK_HALF - 1);
   localparam logic [7:0]  PULSE_L = 8'(TAP_RST_PULSES - 1);

   logic [SYNC_STAGES-1:0] tckc_sync_q, tckc_sync_d, tmsc_sync_q, tmsc_sync_d;
   logic        tckc_prev_q, tmsc_prev_q;
   logic [3:0]  tog_cnt_q, tog_cnt_d;
   logic [1:0]  phase_q, phase_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [11:0] shreg_q, shreg_d;
   logic [15:0] half_cnt_q, half_cnt_d;
   logic [7:0]  pulse_cnt_q, pulse_cnt_d;
   state_t      state_q, state_d;
   logic        tck_q, tck_d, tdi_q, tdi_d, tms_q, tms_d;
   logic        tmsc_q, tmsc_d, oe_q, oe_d, err_q, err_d;

   logic        tckc_s, tmsc_s, tckc_rise, tckc_fall, tmsc_edge, pkt_ok;
   logic [11:0] pkt;

   always_comb begin
      tckc_sync_d = {tckc_sync_q[SYNC_STAGES-2:0], tckc_i};
      tmsc_sync_d = {tmsc_sync_q[SYNC_STAGES-2:0], tmsc_i};
      tckc_s      = tckc_sync_q[SYNC_STAGES-1];
      tmsc_s      = tmsc_sync_q[SYNC_STAGES-1];
      tckc_rise   = tckc_s & ~tckc_prev_q;
      tckc_fall   = ~tckc_s & tckc_prev_q;
      tmsc_edge   = tmsc_s ^ tmsc_prev_q;
      pkt         = {tmsc_s, shreg_q[11:1]};
      pkt_ok      = (pkt[3:0] == OAC) && (pkt[7:4] == EC) && ((CHECK_CP == 0) || (^pkt));
   end

   always_comb begin
      tog_cnt_d   = tog_cnt_q;
      phase_d     = phase_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      half_cnt_d  = half_cnt_q;
      pulse_cnt_d = pulse_cnt_q;
      state_d     = state_q;
      tck_d       = tck_q;
      tdi_d       = tdi_q;
      tms_d       = tms_q;
      tmsc_d      = tmsc_q;
      oe_d        = oe_q;
      err_d       = 1'b0;

      // TMSC edges coinciding with a TCKC edge are dropped (tckc_s high with no rise).
      if (tmsc_edge && tckc_s && !tckc_rise && !oe_q && (tog_cnt_q != 4'hF))
         tog_cnt_d = tog_cnt_q + 4'd1;

      if (state_q == ST_TAPRST) begin
         if (half_cnt_q == HALF_L) begin
            half_cnt_d = '0;
            tck_d      = ~tck_q;
            if (tck_q) begin
               if (pulse_cnt_q == PULSE_L) state_d = ST_OFFLINE;
               else pulse_cnt_d = pulse_cnt_q + 8'd1;
            end
         end else begin
            half_cnt_d = half_cnt_q + 16'd1;
         end
      end else if (tckc_fall) begin
         tog_cnt_d = '0;
         if (tog_cnt_q >= DES_L) begin
            phase_d = '0;
            tck_d   = 1'b0;
            oe_d    = 1'b0;
            if (tog_cnt_q >= RST_L) begin
               state_d     = (TAP_RST_PULSES > 0) ? ST_TAPRST : ST_OFFLINE;
               half_cnt_d  = '0;
               pulse_cnt_d = '0;
            end else if (tog_cnt_q >= SEL_L) begin
               if (state_q == ST_OFFLINE) begin
                  state_d   = ST_ACTIVATE;
                  bit_cnt_d = '0;
               end
            end else if (state_q == ST_ONLINE) begin
               state_d = ST_OFFLINE;
            end
         end else if ((tog_cnt_q == 4'd0) && (state_q == ST_ONLINE)) begin
            // phase_q has already advanced past the rise that opened this half-period
            if (phase_q == 2'd2) begin
               tmsc_d = tdo_i;
               oe_d   = 1'b1;
            end else if (phase_q == 2'd0) begin
               tck_d = 1'b0;
               oe_d  = 1'b0;
            end
         end
      end else if (tckc_rise) begin
         if (state_q == ST_ACTIVATE) begin
            shreg_d   = pkt;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd11) begin
               state_d = pkt_ok ? ST_ONLINE : ST_OFFLINE;
               err_d   = ~pkt_ok;
               phase_d = '0;
            end
         end else if (state_q == ST_ONLINE) begin
            case (phase_q)
               2'd0:    begin tdi_d = ~tmsc_s; phase_d = 2'd1; end
               2'd1:    begin tms_d = tmsc_s;  phase_d = 2'd2; end
               default: begin tck_d = 1'b1;    phase_d = 2'd0; end
            endcase
         end
      end

      if (state_d != ST_ONLINE) begin
         tms_d = 1'b1;
         oe_d  = 1'b0;
         if (state_d != ST_TAPRST) tck_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tckc_sync_q <= '0;
         tmsc_sync_q <= '0;
         tckc_prev_q <= 1'b0;
         tmsc_prev_q <= 1'b0;
         tog_cnt_q   <= '0;
         phase_q     <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         half_cnt_q  <= '0;
         pulse_cnt_q <= '0;
         state_q     <= ST_OFFLINE;
         tck_q       <= 1'b0;
         tdi_q       <= 1'b0;
         tms_q       <= 1'b1;
         tmsc_q      <= 1'b0;
         oe_q        <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         tckc_sync_q <= tckc_sync_d;
         tmsc_sync_q <= tmsc_sync_d;
         tckc_prev_q <= tckc_s;
         tmsc_prev_q <= tmsc_s;
         tog_cnt_q   <= tog_cnt_d;
         phase_q     <= phase_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         half_cnt_q  <= half_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         state_q     <= state_d;
         tck_q       <= tck_d;
         tdi_q       <= tdi_d;
         tms_q       <= tms_d;
         tmsc_q      <= tmsc_d;
         oe_q        <= oe_d;
         err_q       <= err_d;
      end
   end

   assign tmsc_o    = tmsc_q;
   assign tmsc_oe_o = oe_q;
   assign tck_o     = tck_q;
   assign tdi_o     = tdi_q;
   assign tms_o     = tms_q;
   assign err_o     = err_q;
   assign online_o  = (state_q == ST_ONLINE);
   assign state_o   = state_q;

endmodule

// File: tb/tb_cjtag_bridge_v2.sv
// Directed bench for cjtag_bridge_v2: escapes, activation, OScan1 packets, TAP reset, sync reset.
module tb_cjtag_bridge_v2;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       tckc_i = 1'b0;
   logic       tmsc_i = 1'b0;
   logic       tdo_i = 1'b0;
   logic       tmsc_o, tmsc_oe_o, tck_o, tdi_o, tms_o, online_o, err_o;
   logic [2:0] state_o;

   int total = 0;
   int bad   = 0;
   int tck_rises = 0;
   int tms_low_in_tck = 0;
   int err_cycles = 0;
   logic tck_prev = 1'b0;

   cjtag_bridge_v2 dut (
      .clk_i(clk_i), .rst_i(rst_i), .tckc_i(tckc_i), .tmsc_i(tmsc_i),
      .tmsc_o(tmsc_o), .tmsc_oe_o(tmsc_oe_o), .tck_o(tck_o), .tdi_o(tdi_o),
      .tms_o(tms_o), .tdo_i(tdo_i), .online_o(online_o), .err_o(err_o),
      .state_o(state_o)
   );

   always #5 clk_i = ~clk_i;

   // Activity monitors sample the values held through the previous cycle.
   always @(posedge clk_i) begin
      if (tck_o && !tck_prev) tck_rises++;
      if (tck_o && !tms_o) tms_low_in_tck++;
      if (err_o) err_cycles++;
      tck_prev = tck_o;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic clear_monitors();
      tck_rises = 0;
      tms_low_in_tck = 0;
      err_cycles = 0;
   endtask

   task automatic send_bit(input logic b);
      tmsc_i = b;
      wait_clks(6);
      tckc_i = 1'b1;
      wait_clks(6);
      tckc_i = 1'b0;
      wait_clks(6);
   endtask

   task automatic do_escape(input int n);
      tckc_i = 1'b1;
      wait_clks(6);
      for (int i = 0; i < n; i++) begin
         tmsc_i = ~tmsc_i;
         wait_clks(6);
      end
      tckc_i = 1'b0;
      wait_clks(6);
   endtask

   task automatic send_activation(input logic [11:0] v);
      for (int i = 0; i < 12; i++) send_bit(v[i]);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      wait_clks(3);
      total++; if (state_o !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
      total++; if ({tmsc_o, tmsc_oe_o, tck_o, tdi_o, tms_o, online_o, err_o} !== 7'b0000100) begin
         bad++; $display("FAIL reset_outputs got=%b exp=0000100",
                         {tmsc_o, tmsc_oe_o, tck_o, tdi_o, tms_o, online_o, err_o});
      end
      rst_i = 1'b0;
      wait_clks(4);
   endtask

   task automatic test_taprst();
      int guard;
      clear_monitors();
      do_escape(10);
      total++; if (state_o !== 3'd3) begin bad++; $display("FAIL taprst_enter got=%0d exp=3", state_o); end
      guard = 0;
      while (state_o !== 3'd0 && guard < 300) begin wait_clks(1); guard++; end
      total++; if (guard >= 300) begin bad++; $display("FAIL taprst_timeout got=%0d exp=0", state_o); end
      wait_clks(2);
      total++; if (tck_rises !== 5) begin bad++; $display("FAIL taprst_pulses got=%0d exp=5", tck_rises); end
      total++; if (tms_low_in_tck !== 0) begin bad++; $display("FAIL taprst_tms got=%0d exp=0", tms_low_in_tck); end
      total++; if (online_o !== 1'b0 || tck_o !== 1'b0) begin
         bad++; $display("FAIL taprst_exit got=%b%b exp=00", online_o, tck_o); end
   endtask

   task automatic test_activation();
      do_escape(7);
      total++; if (state_o !== 3'd1) begin bad++; $display("FAIL act_select got=%0d exp=1", state_o); end
      for (int i = 0; i < 11; i++) send_bit(i inside {2, 3, 7});
      total++; if (state_o !== 3'd1) begin bad++; $display("FAIL act_11bits got=%0d exp=1", state_o); end
      send_bit(1'b0);
      total++; if (state_o !== 3'd2 || online_o !== 1'b1) begin
         bad++; $display("FAIL act_online got=%0d/%b exp=2/1", state_o, online_o); end
   endtask

   task automatic run_packet(input logic ntdi, input logic tms, input logic tdo, input string nm);
      clear_monitors();
      tdo_i = tdo;
      send_bit(ntdi);
      total++; if (tdi_o !== ~ntdi) begin bad++; $display("FAIL %s_tdi got=%b exp=%b", nm, tdi_o, ~ntdi); end
      tmsc_i = tms;
      wait_clks(6);
      tckc_i = 1'b1;
      wait_clks(6);
      total++; if (tms_o !== tms || tck_o !== 1'b0) begin
         bad++; $display("FAIL %s_tms got=%b/%b exp=%b/0", nm, tms_o, tck_o, tms); end
      tckc_i = 1'b0;
      wait_clks(6);
      tckc_i = 1'b1;
      wait_clks(6);
      total++; if (tck_o !== 1'b1 || tmsc_oe_o !== 1'b1 || tmsc_o !== tdo) begin
         bad++; $display("FAIL %s_phase2 got=%b%b%b exp=11%b", nm, tck_o, tmsc_oe_o, tmsc_o, tdo); end
      total++; if (tdi_o !== ~ntdi) begin bad++; $display("FAIL %s_tdi_hold got=%b exp=%b", nm, tdi_o, ~ntdi); end
      tckc_i = 1'b0;
      wait_clks(6);
      total++; if (tck_o !== 1'b0 || tmsc_oe_o !== 1'b0) begin
         bad++; $display("FAIL %s_end got=%b%b exp=00", nm, tck_o, tmsc_oe_o); end
      total++; if (tck_rises !== 1) begin bad++; $display("FAIL %s_pulses got=%0d exp=1", nm, tck_rises); end
   endtask

   task automatic test_online_packet();
      run_packet(1'b0, 1'b1, 1'b1, "pkt_a");
   endtask

   task automatic test_back_to_back();
      run_packet(1'b1, 1'b0, 1'b0, "pkt_b");
      run_packet(1'b0, 1'b1, 1'b0, "pkt_c");
   endtask

   task automatic test_deselect_glitch();
      clear_monitors();
      do_escape(5);
      total++; if (state_o !== 3'd0 || tms_o !== 1'b1) begin
         bad++; $display("FAIL deselect got=%0d/%b exp=0/1", state_o, tms_o); end
      do_escape(2);
      total++; if (state_o !== 3'd0) begin bad++; $display("FAIL glitch got=%0d exp=0", state_o); end
      do_escape(4);
      total++; if (state_o !== 3'd0) begin bad++; $display("FAIL deselect_offline got=%0d exp=0", state_o); end
      do_escape(6);
      total++; if (state_o !== 3'd1) begin bad++; $display("FAIL reselect got=%0d exp=1", state_o); end
      total++; if (tck_rises !== 0) begin bad++; $display("FAIL escape_tck got=%0d exp=0", tck_rises); end
   endtask

   task automatic test_bad_activation();
      clear_monitors();
      send_activation(12'b0000_1000_1110);
      total++; if (err_cycles !== 1) begin bad++; $display("FAIL bad_act_err got=%0d exp=1", err_cycles); end
      total++; if (state_o !== 3'd0 || online_o !== 1'b0) begin
         bad++; $display("FAIL bad_act_state got=%0d/%b exp=0/0", state_o, online_o); end
      total++; if (tck_rises !== 0) begin bad++; $display("FAIL bad_act_tck got=%0d exp=0", tck_rises); end
   endtask

   task automatic test_rst_mid_packet();
      do_escape(7);
      send_activation(12'b0000_1000_1100);
      total++; if (state_o !== 3'd2) begin bad++; $display("FAIL rst_pre_online got=%0d exp=2", state_o); end
      tdo_i = 1'b1;
      send_bit(1'b0);
      send_bit(1'b1);
      tckc_i = 1'b1;
      wait_clks(6);
      total++; if (tck_o !== 1'b1 || tmsc_oe_o !== 1'b1) begin
         bad++; $display("FAIL rst_pre_phase2 got=%b%b exp=11", tck_o, tmsc_oe_o); end
      rst_i = 1'b1;
      wait_clks(1);
      total++; if (tck_o !== 1'b0 || tmsc_oe_o !== 1'b0 || tms_o !== 1'b1 || state_o !== 3'd0) begin
         bad++; $display("FAIL rst_mid got=%b%b%b/%0d exp=001/0", tck_o, tmsc_oe_o, tms_o, state_o); end
      tckc_i = 1'b0;
      tmsc_i = 1'b0;
      wait_clks(2);
      rst_i = 1'b0;
      wait_clks(6);
      total++; if (online_o !== 1'b0 || state_o !== 3'd0) begin
         bad++; $display("FAIL rst_after got=%b/%0d exp=0/0", online_o, state_o); end
   endtask

   initial begin
      test_reset();
      test_taprst();
      test_activation();
      test_online_packet();
      test_back_to_back();
      test_deselect_glitch();
      test_bad_activation();
      test_rst_mid_packet();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
